// File: rtl/rf_write.sv
// Register-file entry store: owns the packed per-core {valid, retriving, locked, tag, val}
// vector and applies core requests and memory fill responses with one cycle of latency.
module rf_write #(
  parameter  int NCORES = 4,
  localparam int CW     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Handshake: a request transfers on a cycle where req_valid && req_ready; while
  // stalled the requester holds req_core/op/tag/data stable. Fills are always accepted.
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CW-1:0]        req_core,
  input  logic [1:0]           req_op,
  input  logic [15:0]          req_tag,
  input  logic [15:0]          req_data,
  output logic                 req_err,
  input  logic                 fill_valid,
  output logic                 fill_ready,
  input  logic [CW-1:0]        fill_core,
  input  logic [15:0]          fill_tag,
  input  logic [15:0]          fill_data,
  output logic                 fill_drop,
  output logic [NCORES*35-1:0] rf_out
);

  localparam logic [1:0]  OP_FETCH  = 2'b00;
  localparam logic [1:0]  OP_WRITE  = 2'b01;
  localparam logic [1:0]  OP_LOCK   = 2'b10;
  localparam logic [1:0]  OP_UNLOCK = 2'b11;
  localparam logic [CW:0] NC_LIM    = (CW+1)'(NCORES);

  logic [NCORES-1:0] valid_q;
  logic [NCORES-1:0] ret_q;
  logic [NCORES-1:0] lock_q;
  logic [15:0]       tag_q [NCORES];
  logic [15:0]       val_q [NCORES];

  logic req_in;
  logic fill_in;
  logic req_fire;
  logic sel_valid;
  logic sel_ret;
  logic sel_lock;
  logic fill_hit;

  assign req_in   = ({1'b0, req_core} < NC_LIM);
  assign fill_in  = ({1'b0, fill_core} < NC_LIM);
  assign req_fire = req_valid && req_ready;
  assign fill_ready = 1'b1;

  // Out-of-range indices read as an all-zero entry so no array access goes out of bounds.
  always_comb begin
    sel_valid = 1'b0;
    sel_ret   = 1'b0;
    sel_lock  = 1'b0;
    if (req_in) begin
      sel_valid = valid_q[req_core];
      sel_ret   = ret_q[req_core];
      sel_lock  = lock_q[req_core];
    end
  end

  always_comb begin
    req_ready = 1'b1;
    if (req_in) begin
      case (req_op)
        OP_FETCH: req_ready = !sel_ret && !sel_lock;
        OP_LOCK:  req_ready = !sel_lock;
        default:  req_ready = 1'b1;
      endcase
    end
  end

  always_comb begin
    fill_hit = 1'b0;
    if (fill_in) begin
      fill_hit = ret_q[fill_core] && (tag_q[fill_core] == fill_tag);
    end
  end

  // Request and fill both look at pre-edge state; the legality rules keep them off the
  // same fields of one entry, so both may update in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      ret_q     <= '0;
      lock_q    <= '0;
      req_err   <= 1'b0;
      fill_drop <= 1'b0;
      for (int i = 0; i < NCORES; i++) begin
        tag_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else begin
      req_err   <= 1'b0;
      fill_drop <= 1'b0;

      if (req_fire) begin
        if (!req_in) begin
          req_err <= 1'b1;
        end else begin
          case (req_op)
            OP_FETCH: begin
              tag_q[req_core]   <= req_tag;
              ret_q[req_core]   <= 1'b1;
              valid_q[req_core] <= 1'b0;
            end
            OP_WRITE: begin
              if (sel_valid && sel_lock) val_q[req_core] <= req_data;
              else                       req_err         <= 1'b1;
            end
            OP_LOCK:   lock_q[req_core] <= 1'b1;
            OP_UNLOCK: lock_q[req_core] <= 1'b0;
            default: ;
          endcase
        end
      end

      if (fill_valid) begin
        if (fill_hit) begin
          val_q[fill_core]   <= fill_data;
          valid_q[fill_core] <= 1'b1;
          ret_q[fill_core]   <= 1'b0;
        end else begin
          fill_drop <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rf_out = '0;
    for (int i = 0; i < NCORES; i++) begin
      rf_out[i*35 +: 35] = {valid_q[i], ret_q[i], lock_q[i], tag_q[i], val_q[i]};
    end
  end

endmodule

// File: tb/tb_rf_write.sv
// Directed self-checking bench for rf_write: fetch/fill, drops, locking, writes,
// simultaneous request+fill, back-to-back requests and reset mid-fetch.
module tb_rf_write;

  localparam int NCORES = 4;
  localparam int CW     = 2;
  localparam logic [1:0] OP_FETCH  = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_LOCK   = 2'b10;
  localparam logic [1:0] OP_UNLOCK = 2'b11;

  logic                 clk;
  logic                 rst_n;
  logic                 req_valid;
  logic                 req_ready;
  logic [CW-1:0]        req_core;
  logic [1:0]           req_op;
  logic [15:0]          req_tag;
  logic [15:0]          req_data;
  logic                 req_err;
  logic                 fill_valid;
  logic                 fill_ready;
  logic [CW-1:0]        fill_core;
  logic [15:0]          fill_tag;
  logic [15:0]          fill_data;
  logic                 fill_drop;
  logic [NCORES*35-1:0] rf_out;

  int checks = 0;
  int errors = 0;

  rf_write #(.NCORES(NCORES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_core(req_core),
    .req_op(req_op), .req_tag(req_tag), .req_data(req_data), .req_err(req_err),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_core(fill_core),
    .fill_tag(fill_tag), .fill_data(fill_data), .fill_drop(fill_drop),
    .rf_out(rf_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Helpers and driver tasks
  function automatic logic [34:0] mk(input logic v, input logic r, input logic l,
                                     input logic [15:0] t, input logic [15:0] d);
    return {v, r, l, t, d};
  endfunction

  function automatic logic [34:0] ent(input int i);
    return rf_out[i*35 +: 35];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [CW-1:0] core,
                           input logic [15:0] tag, input logic [15:0] data);
    req_valid = 1'b1;
    req_op    = op;
    req_core  = core;
    req_tag   = tag;
    req_data  = data;
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
  endtask

  task automatic drive_fill(input logic [CW-1:0] core, input logic [15:0] tag,
                            input logic [15:0] data);
    fill_valid = 1'b1;
    fill_core  = core;
    fill_tag   = tag;
    fill_data  = data;
    #1;
  endtask

  task automatic idle_fill();
    fill_valid = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_core = '0; req_op = OP_FETCH; req_tag = '0; req_data = '0;
    fill_valid = 1'b0; fill_core = '0; fill_tag = '0; fill_data = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    checks++;
    if (rf_out !== '0) begin errors++; $display("FAIL reset_rf_out got=%h exp=0", rf_out); end
    checks++;
    if (req_err !== 1'b0) begin errors++; $display("FAIL reset_req_err got=%b exp=0", req_err); end
    checks++;
    if (fill_drop !== 1'b0) begin errors++; $display("FAIL reset_fill_drop got=%b exp=0", fill_drop); end
    checks++;
    if (fill_ready !== 1'b1) begin errors++; $display("FAIL reset_fill_ready got=%b exp=1", fill_ready); end
    for (int c = 0; c < NCORES; c++) begin
      req_op = OP_FETCH;
      req_core = CW'(c);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready core=%0d got=%b exp=1", c, req_ready); end
    end
  endtask

  task automatic test_fetch_fill();
    drive_req(OP_FETCH, 2'd2, 16'h1234, 16'h0000);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready got=%b exp=1", req_ready); end
    tick();
    idle_req();
    checks++;
    if (ent(2) !== mk(0, 1, 0, 16'h1234, 16'h0000)) begin errors++; $display("FAIL fetch_pending got=%h exp=%h", ent(2), mk(0, 1, 0, 16'h1234, 16'h0000)); end
    tick();
    drive_fill(2'd2, 16'h1234, 16'hBEEF);
    tick();
    idle_fill();
    checks++;
    if (ent(2) !== mk(1, 0, 0, 16'h1234, 16'hBEEF)) begin errors++; $display("FAIL fill_ready_entry got=%h exp=%h", ent(2), mk(1, 0, 0, 16'h1234, 16'hBEEF)); end
    checks++;
    if (fill_drop !== 1'b0) begin errors++; $display("FAIL fill_hit_no_drop got=%b exp=0", fill_drop); end
  endtask

  task automatic test_fill_drop();
    drive_fill(2'd1, 16'h0001, 16'h7777);
    tick();
    idle_fill();
    checks++;
    if (fill_drop !== 1'b1) begin errors++; $display("FAIL drop_empty got=%b exp=1", fill_drop); end
    checks++;
    if (ent(1) !== '0) begin errors++; $display("FAIL drop_empty_entry got=%h exp=0", ent(1)); end
    tick();
    checks++;
    if (fill_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse_width got=%b exp=0", fill_drop); end
    drive_req(OP_FETCH, 2'd1, 16'h00AA, 16'h0000);
    tick();
    idle_req();
    drive_fill(2'd1, 16'h00AB, 16'h9999);
    tick();
    idle_fill();
    checks++;
    if (fill_drop !== 1'b1) begin errors++; $display("FAIL drop_tag_mismatch got=%b exp=1", fill_drop); end
    checks++;
    if (ent(1) !== mk(0, 1, 0, 16'h00AA, 16'h0000)) begin errors++; $display("FAIL drop_stays_pending got=%h exp=%h", ent(1), mk(0, 1, 0, 16'h00AA, 16'h0000)); end
  endtask

  task automatic test_lock();
    drive_req(OP_LOCK, 2'd0, 16'h0000, 16'h0000);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL lock_first_ready got=%b exp=1", req_ready); end
    tick();
    checks++;
    if (ent(0) !== mk(0, 0, 1, 16'h0000, 16'h0000)) begin errors++; $display("FAIL lock_set got=%h exp=%h", ent(0), mk(0, 0, 1, 16'h0000, 16'h0000)); end
    // Second LOCK stays pending for a few cycles with its fields held
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL lock_second_stall got=%b exp=0", req_ready); end
    repeat (2) tick();
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL lock_still_stalled got=%b exp=0", req_ready); end
    checks++;
    if (req_err !== 1'b0) begin errors++; $display("FAIL lock_stall_no_err got=%b exp=0", req_err); end
    idle_req();
    req_op = OP_FETCH;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL fetch_locked_stall got=%b exp=0", req_ready); end
    drive_req(OP_UNLOCK, 2'd0, 16'h0000, 16'h0000);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL unlock_ready got=%b exp=1", req_ready); end
    tick();
    idle_req();
    checks++;
    if (ent(0) !== '0) begin errors++; $display("FAIL unlock_cleared got=%h exp=0", ent(0)); end
    req_op = OP_LOCK;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL lock_ready_after_unlock got=%b exp=1", req_ready); end
  endtask

  task automatic test_write();
    drive_req(OP_FETCH, 2'd3, 16'h0303, 16'h0000);
    tick();
    idle_req();
    drive_fill(2'd3, 16'h0303, 16'h1111);
    tick();
    idle_fill();
    checks++;
    if (ent(3) !== mk(1, 0, 0, 16'h0303, 16'h1111)) begin errors++; $display("FAIL write_setup got=%h exp=%h", ent(3), mk(1, 0, 0, 16'h0303, 16'h1111)); end
    drive_req(OP_WRITE, 2'd3, 16'h0000, 16'h5555);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL write_ready got=%b exp=1", req_ready); end
    tick();
    idle_req();
    checks++;
    if (req_err !== 1'b1) begin errors++; $display("FAIL write_unlocked_err got=%b exp=1", req_err); end
    checks++;
    if (ent(3) !== mk(1, 0, 0, 16'h0303, 16'h1111)) begin errors++; $display("FAIL write_unlocked_unchanged got=%h exp=%h", ent(3), mk(1, 0, 0, 16'h0303, 16'h1111)); end
    tick();
    checks++;
    if (req_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width got=%b exp=0", req_err); end
    drive_req(OP_LOCK, 2'd3, 16'h0000, 16'h0000);
    tick();
    drive_req(OP_WRITE, 2'd3, 16'h0000, 16'h5555);
    tick();
    idle_req();
    checks++;
    if (req_err !== 1'b0) begin errors++; $display("FAIL write_locked_no_err got=%b exp=0", req_err); end
    checks++;
    if (ent(3) !== mk(1, 0, 1, 16'h0303, 16'h5555)) begin errors++; $display("FAIL write_locked_val got=%h exp=%h", ent(3), mk(1, 0, 1, 16'h0303, 16'h5555)); end
    // Unlocking an already-unlocked entry is a legal no-op
    drive_req(OP_UNLOCK, 2'd2, 16'h0000, 16'h0000);
    tick();
    idle_req();
    checks++;
    if (req_err !== 1'b0) begin errors++; $display("FAIL unlock_noop_err got=%b exp=0", req_err); end
    checks++;
    if (ent(2) !== mk(1, 0, 0, 16'h1234, 16'hBEEF)) begin errors++; $display("FAIL unlock_noop_entry got=%h exp=%h", ent(2), mk(1, 0, 0, 16'h1234, 16'hBEEF)); end
  endtask

  task automatic test_simultaneous();
    // Core 1 is PENDING on tag 0x00AA
    drive_req(OP_LOCK, 2'd1, 16'h0000, 16'h0000);
    drive_fill(2'd1, 16'h00AA, 16'hCAFE);
    tick();
    idle_req();
    idle_fill();
    checks++;
    if (ent(1) !== mk(1, 0, 1, 16'h00AA, 16'hCAFE)) begin errors++; $display("FAIL lock_and_fill got=%h exp=%h", ent(1), mk(1, 0, 1, 16'h00AA, 16'hCAFE)); end
    checks++;
    if (fill_drop !== 1'b0) begin errors++; $display("FAIL lock_and_fill_drop got=%b exp=0", fill_drop); end
    checks++;
    if (req_err !== 1'b0) begin errors++; $display("FAIL lock_and_fill_err got=%b exp=0", req_err); end
  endtask

  task automatic test_back_to_back();
    drive_req(OP_UNLOCK, 2'd1, 16'h0000, 16'h0000);
    tick();
    drive_req(OP_FETCH, 2'd2, 16'h2222, 16'h0000);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_fetch_ready got=%b exp=1", req_ready); end
    checks++;
    if (ent(1) !== mk(1, 0, 0, 16'h00AA, 16'hCAFE)) begin errors++; $display("FAIL b2b_unlock got=%h exp=%h", ent(1), mk(1, 0, 0, 16'h00AA, 16'hCAFE)); end
    tick();
    idle_req();
    checks++;
    if (ent(2) !== mk(0, 1, 0, 16'h2222, 16'hBEEF)) begin errors++; $display("FAIL b2b_fetch got=%h exp=%h", ent(2), mk(0, 1, 0, 16'h2222, 16'hBEEF)); end
  endtask

  task automatic test_reset_mid();
    drive_req(OP_FETCH, 2'd0, 16'h0F0F, 16'h0000);
    tick();
    idle_req();
    checks++;
    if (ent(0) !== mk(0, 1, 0, 16'h0F0F, 16'h0000)) begin errors++; $display("FAIL rstmid_pending got=%h exp=%h", ent(0), mk(0, 1, 0, 16'h0F0F, 16'h0000)); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rf_out !== '0) begin errors++; $display("FAIL rstmid_async_clear got=%h exp=0", rf_out); end
    #1 rst_n = 1'b1;
    drive_fill(2'd0, 16'h0F0F, 16'h1234);
    tick();
    idle_fill();
    checks++;
    if (fill_drop !== 1'b1) begin errors++; $display("FAIL rstmid_fill_dropped got=%b exp=1", fill_drop); end
    checks++;
    if (ent(0) !== '0) begin errors++; $display("FAIL rstmid_entry got=%h exp=0", ent(0)); end
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_fetch_fill();
    test_fill_drop();
    test_lock();
    test_write();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
